// File: rtl/vend_pkg.sv
// Shared types, constants and helpers for the vending credit controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CREDIT,
    VEND,
    CHANGE
  } state_t;

  localparam int COIN_IDX_W = 2;
  localparam int NUM_COINS  = 4;
  localparam int VEC_MAX_W  = 256;

  localparam logic [31:0] DEF_PRICES    = {8'd12, 8'd7, 8'd5, 8'd3};
  localparam logic [31:0] DEF_COIN_VALS = {8'd10, 8'd5, 8'd2, 8'd1};

  // Extracts field idx of width w from a packed price vector.
  function automatic logic [31:0] get_price(input logic [VEC_MAX_W-1:0] prices,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [VEC_MAX_W-1:0] shifted;
    shifted   = prices >> (idx * w);
    get_price = shifted[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vend_change_pick.sv
// Greedy change selector: largest coin whose value fits in the remaining credit.
module vend_change_pick
  import vend_pkg::*;
#(
  parameter int                      CREDIT_W  = 8,
  parameter logic [4*CREDIT_W-1:0]   COIN_VALS = (4*CREDIT_W)'(DEF_COIN_VALS)
) (
  input  logic [CREDIT_W-1:0]   credit,
  output logic [COIN_IDX_W-1:0] coin_idx
);

  // Coin values ascend with index, so the last fitting index is the largest coin.
  always_comb begin
    coin_idx = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (COIN_VALS[i*CREDIT_W +: CREDIT_W] <= credit) coin_idx = COIN_IDX_W'(i);
    end
  end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending controller: credit accumulation, priced vend and greedy change return.
module vend_credit_ctrl
  import vend_pkg::*;
#(
  parameter int                              CREDIT_W   = 8,
  parameter int                              NUM_ITEMS  = 4,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0]   PRICES     = (NUM_ITEMS*CREDIT_W)'(DEF_PRICES),
  parameter logic [4*CREDIT_W-1:0]           COIN_VALS  = (4*CREDIT_W)'(DEF_COIN_VALS),
  parameter int                              MAX_CREDIT = 20,
  localparam int                             ITEM_W     = $clog2(NUM_ITEMS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  coin_vld,
  input  logic [COIN_IDX_W-1:0] coin_sel,
  input  logic                  sel_vld,
  input  logic [ITEM_W-1:0]     sel_item,
  input  logic                  cancel,
  input  logic                  chg_ack,
  output logic                  dispense,
  output logic [ITEM_W-1:0]     disp_item,
  output logic                  chg_vld,
  output logic [COIN_IDX_W-1:0] chg_coin,
  output logic                  coin_rej,
  output logic                  price_short,
  output logic [CREDIT_W-1:0]   credit,
  output logic                  busy
);

  state_t                state;
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W-1:0]   chg_val;
  logic [CREDIT_W-1:0]   price;
  logic [CREDIT_W:0]     credit_sum;
  logic                  item_ok;
  logic                  sum_fits;
  logic [COIN_IDX_W-1:0] pick_idx;

  assign coin_val   = COIN_VALS[coin_sel*CREDIT_W +: CREDIT_W];
  assign chg_val    = COIN_VALS[chg_coin*CREDIT_W +: CREDIT_W];
  assign price      = CREDIT_W'(get_price(VEC_MAX_W'(PRICES), 32'(sel_item), 32'(CREDIT_W)));
  // One extra bit keeps the ceiling compare from wrapping.
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign sum_fits   = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
  assign item_ok    = {1'b0, sel_item} < (ITEM_W+1)'(NUM_ITEMS);

  vend_change_pick #(
    .CREDIT_W  (CREDIT_W),
    .COIN_VALS (COIN_VALS)
  ) u_change_pick (
    .credit   (credit),
    .coin_idx (pick_idx)
  );

  // NOTE: all state and outputs update with non-blocking assignments so every
  // read in this block sees the pre-edge value, matching the hardware registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      credit      <= '0;
      dispense    <= 1'b0;
      disp_item   <= '0;
      chg_vld     <= 1'b0;
      chg_coin    <= '0;
      coin_rej    <= 1'b0;
      price_short <= 1'b0;
      busy        <= 1'b0;
    end else begin
      dispense    <= 1'b0;
      coin_rej    <= 1'b0;
      price_short <= 1'b0;
      unique case (state)
        IDLE, CREDIT: begin
          if (cancel) begin
            coin_rej <= coin_vld;
            if (credit != '0) begin
              state <= CHANGE;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (sel_vld && item_ok && credit >= price) begin
            state     <= VEND;
            credit    <= credit - price;
            dispense  <= 1'b1;
            disp_item <= sel_item;
            busy      <= 1'b1;
            coin_rej  <= coin_vld;
          end else begin
            price_short <= sel_vld;
            if (coin_vld) begin
              if (sum_fits) begin
                credit <= credit_sum[CREDIT_W-1:0];
                state  <= CREDIT;
              end else begin
                coin_rej <= 1'b1;
              end
            end
          end
        end
        VEND: begin
          coin_rej <= coin_vld;
          if (credit != '0) begin
            state <= CHANGE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CHANGE: begin
          coin_rej <= coin_vld;
          // chg_vld idles low for a cycle before each coin is presented.
          if (!chg_vld) begin
            chg_vld  <= 1'b1;
            chg_coin <= pick_idx;
          end else if (chg_ack) begin
            chg_vld <= 1'b0;
            credit  <= credit - chg_val;
            if (credit == chg_val) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed self-checking bench for vend_credit_ctrl with default parameters.
module tb_vend_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_vld = 1'b0;
  logic [1:0] coin_sel = '0;
  logic       sel_vld = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       chg_ack = 1'b0;
  logic       dispense;
  logic [1:0] disp_item;
  logic       chg_vld;
  logic [1:0] chg_coin;
  logic       coin_rej;
  logic       price_short;
  logic [7:0] credit;
  logic       busy;

  int n_assert = 0;
  int n_fail   = 0;

  vend_credit_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .coin_vld    (coin_vld),
    .coin_sel    (coin_sel),
    .sel_vld     (sel_vld),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .chg_ack     (chg_ack),
    .dispense    (dispense),
    .disp_item   (disp_item),
    .chg_vld     (chg_vld),
    .chg_coin    (chg_coin),
    .coin_rej    (coin_rej),
    .price_short (price_short),
    .credit      (credit),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    coin_vld = 1'b0;
    sel_vld  = 1'b0;
    cancel   = 1'b0;
    chg_ack  = 1'b0;
  endtask

  task automatic insert(input logic [1:0] sel);
    coin_vld = 1'b1;
    coin_sel = sel;
    cycle();
  endtask

  task automatic choose(input logic [1:0] item);
    sel_vld  = 1'b1;
    sel_item = item;
    cycle();
  endtask

  task automatic wait_vld(input string tag);
    int n = 0;
    while (!chg_vld && n < 8) begin
      cycle();
      n++;
    end
    chk({tag, "_vld"}, 32'(chg_vld), 32'd1);
  endtask

  task automatic give_change(input string tag, input logic [1:0] exp_coin,
                             input logic [7:0] exp_credit);
    wait_vld(tag);
    if (chg_vld) begin
      chk({tag, "_coin"}, 32'(chg_coin), 32'(exp_coin));
      chg_ack = 1'b1;
      cycle();
      chk({tag, "_credit"}, 32'(credit), 32'(exp_credit));
      chk({tag, "_drop"}, 32'(chg_vld), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credit", 32'(credit), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_chg_vld", 32'(chg_vld), 32'd0);
    chk("rst_dispense", 32'(dispense), 32'd0);
    rst = 1'b1;
    cycle();

    // 1: 10 in, item 2 (7) out, change 2 then 1.
    insert(2'd3);
    chk("t1_credit10", 32'(credit), 32'd10);
    chk("t1_busy_idle", 32'(busy), 32'd0);
    choose(2'd2);
    chk("t1_dispense", 32'(dispense), 32'd1);
    chk("t1_disp_item", 32'(disp_item), 32'd2);
    chk("t1_credit3", 32'(credit), 32'd3);
    chk("t1_busy", 32'(busy), 32'd1);
    cycle();
    chk("t1_disp_pulse", 32'(dispense), 32'd0);
    give_change("t1_c1", 2'd1, 8'd1);
    give_change("t1_c2", 2'd0, 8'd0);
    cycle();
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: insufficient credit, then top up and vend.
    insert(2'd1);
    choose(2'd1);
    chk("t2_short", 32'(price_short), 32'd1);
    chk("t2_credit2", 32'(credit), 32'd2);
    chk("t2_no_disp", 32'(dispense), 32'd0);
    insert(2'd2);
    chk("t2_credit7", 32'(credit), 32'd7);
    choose(2'd1);
    chk("t2_dispense", 32'(dispense), 32'd1);
    chk("t2_disp_item", 32'(disp_item), 32'd1);
    chk("t2_credit2b", 32'(credit), 32'd2);
    give_change("t2_c1", 2'd1, 8'd0);

    // 3: ceiling reject, then select with a same-cycle coin.
    insert(2'd3);
    insert(2'd3);
    chk("t3_credit20", 32'(credit), 32'd20);
    insert(2'd0);
    chk("t3_rej_max", 32'(coin_rej), 32'd1);
    chk("t3_credit_hold", 32'(credit), 32'd20);
    sel_vld  = 1'b1;
    sel_item = 2'd3;
    coin_vld = 1'b1;
    coin_sel = 2'd2;
    cycle();
    chk("t3_dispense", 32'(dispense), 32'd1);
    chk("t3_disp_item", 32'(disp_item), 32'd3);
    chk("t3_rej_sel", 32'(coin_rej), 32'd1);
    chk("t3_credit8", 32'(credit), 32'd8);
    give_change("t3_c1", 2'd2, 8'd3);
    give_change("t3_c2", 2'd1, 8'd1);
    give_change("t3_c3", 2'd0, 8'd0);

    // 4/5: cancel refund, coin and early ack during CHANGE, stalled ack.
    insert(2'd2);
    insert(2'd2);
    cancel = 1'b1;
    cycle();
    chk("t4_busy", 32'(busy), 32'd1);
    chk("t4_credit10", 32'(credit), 32'd10);
    coin_vld = 1'b1;
    coin_sel = 2'd0;
    chg_ack  = 1'b1;
    cycle();
    chk("t4_rej_chg", 32'(coin_rej), 32'd1);
    chk("t4_credit_keep", 32'(credit), 32'd10);
    chk("t4_vld", 32'(chg_vld), 32'd1);
    chk("t4_coin", 32'(chg_coin), 32'd3);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_hold_vld", 32'(chg_vld), 32'd1);
      chk("t5_hold_coin", 32'(chg_coin), 32'd3);
      chk("t5_hold_credit", 32'(credit), 32'd10);
    end
    chg_ack = 1'b1;
    cycle();
    chk("t5_ack_credit", 32'(credit), 32'd0);
    chk("t5_ack_vld", 32'(chg_vld), 32'd0);
    chk("t5_idle", 32'(busy), 32'd0);

    // 6: asynchronous reset in the middle of CHANGE.
    insert(2'd1);
    insert(2'd0);
    chk("t6_credit3", 32'(credit), 32'd3);
    cancel = 1'b1;
    cycle();
    wait_vld("t6");
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_credit", 32'(credit), 32'd0);
    chk("t6_rst_vld", 32'(chg_vld), 32'd0);
    chk("t6_rst_coin", 32'(chg_coin), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_item", 32'(disp_item), 32'd0);
    cycle();
    rst = 1'b1;
    cycle();
    choose(2'd0);
    chk("t6_short", 32'(price_short), 32'd1);
    chk("t6_credit0", 32'(credit), 32'd0);
    chk("t6_no_disp", 32'(dispense), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
